fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the rv32 execute datapath.
- Generates sequential PCs and requests words from instruction memory over a req/ack handshake that tolerates variable latency.
- Buffers returned {pc, instruction} pairs in a small prefetch queue.
- Presents them to the core over a valid/ready interface; the core redirects fetch on jal/jalr/taken branch.

Parameters:
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- DEPTH, 2: prefetch queue entries (power of two, ≥2).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_req  output  1  fetch request, held until imem_ack.
- imem_addr  output  32  word-aligned fetch address; stable while imem_req is high.
- imem_ack  input  1  response valid; imem_data is sampled this cycle.
- imem_data  input  32  instruction word.
- redirect  input  1  one-cycle pulse: flush and restart fetch.
- redirect_pc  input  32  new fetch target; bits [1:0] are ignored and forced to 00.
- ins_valid  output  1  queue head valid.
- ins  output  32  instruction at queue head.
- ins_pc  output  32  PC of the instruction at queue head.
- ins_ready  input  1  core accepts the head this cycle.

Behaviour:
- Reset (async assert, sync deassert by design):
  - imem_req=0, imem_addr=RESET_PC, ins_valid=0, ins=0, ins_pc=0.
  - Queue empty, fetch_pc=RESET_PC, FSM=IDLE.
- FSM states:
  - IDLE: no outstanding request. If credit is available, assert imem_req with imem_addr=fetch_pc and go to WAIT. Credit means queue occupancy + outstanding < DEPTH.
  - WAIT: imem_req stays high with a constant address until imem_ack.
    - On ack, push {fetch_pc, imem_data} and set fetch_pc += 4 (mod 2^32; 0xFFFF_FFFC wraps to 0).
    - If credit remains after the push, issue the next request the same cycle (back-to-back, remain in WAIT). Otherwise go to IDLE.
  - DROP: a redirect arrived while a request was outstanding. imem_req stays high with the stale address until ack. The ack data is discarded (no push), then the FSM goes to IDLE using the new fetch_pc.
- Redirect:
  - In any state, the queue is flushed in the same cycle and fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - From IDLE: the new request is issued the next cycle.
  - From WAIT with no ack that cycle: go to DROP.
  - From WAIT with an ack that cycle: the ack is discarded and the FSM goes to IDLE.
  - Redirect while in DROP: the target is overwritten and the FSM remains in DROP.
- Output:
  - ins_valid = queue non-empty; ins/ins_pc come from the head entry, are registered, and have no combinational path from imem_data.
  - Pop when ins_valid & ins_ready.
  - Redirect and pop in the same cycle: redirect wins (flush); the pop has no extra effect.
  - Push and pop in the same cycle are both allowed; occupancy is unchanged.
- Timing: minimum latency from imem_ack to ins_valid is 1 cycle. Sustained throughput is 1 instruction per cycle when imem acks in the same cycle and DEPTH ≥ 2.
- Overflow is impossible by the credit rule. Popping when empty is ignored.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds output port stall_cnt [31:0], which counts cycles with ins_ready=1 & ins_valid=0.
  - Adds output port flush_cnt [31:0], which counts redirect pulses.
  - Both reset to 0, saturate at 32'hFFFF_FFFF, and are not cleared by redirect.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package (fetch_pkg):
  - FSM state encoding (IDLE, WAIT, DROP).
  - Default RESET_PC constant.
  - Queue-entry record {pc[31:0], ins[31:0]}.
  - INS_BYTES=4 constant.
- Sub-module fetch_fifo:
  - Synchronous FIFO with DEPTH parameter and synchronous flush.
  - Flags full/empty and an occupancy count.
  - fetch_unit owns the FSM, fetch_pc and the credit logic.

Test Plan:
1. Reset release, imem acks same cycle, ins_ready=1 → requests at 0x0,0x4,0x8…; ins_pc sequence 0x0,0x4,0x8 one per cycle starting 1 cycle after first ack.
2. ins_ready=0 for 10 cycles → exactly 2 entries (0x0,0x4) buffered, imem_req low after second ack; releasing ready drains 0x0,0x4 then resumes at 0x8.
3. imem ack latency 3 cycles, redirect to 0x100 one cycle after request to 0x8 issues → 0x8 data discarded, next imem_addr=0x100, first ins_pc after redirect = 0x100.
4. Redirect with redirect_pc=0x203 coincident with pop and an ack → queue empty next cycle, next imem_addr=0x200, no stale instruction ever presented.
5. RESET_PC=0xFFFF_FFF8 → fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 in order.
6. With FETCH_PERF_EN: hold ins_ready=1, delay acks 4 cycles over 3 fetches, 2 redirects → stall_cnt and flush_cnt match the bench model exactly (flush_cnt=2); assert rst mid-WAIT → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          INS_BYTES        = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } fetch_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] a);
        return a & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction-memory request/ack side plus core-facing valid/ready side.
interface fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ins_valid;
    logic [31:0] ins;
    logic [31:0] ins_pc;
    logic        ins_ready;

    modport master (
        output imem_req, imem_addr, ins_valid, ins, ins_pc,
        input  imem_ack, imem_data, redirect, redirect_pc, ins_ready
    );

    modport slave (
        input  imem_req, imem_addr, ins_valid, ins, ins_pc,
        output imem_ack, imem_data, redirect, redirect_pc, ins_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// Prefetch queue of {pc, ins} entries with synchronous flush and occupancy count.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty,
    output logic [CW-1:0] count
);
    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic          do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC generation, imem req/ack, prefetch queue, redirect.
// Optional FETCH_PERF_EN adds saturating stall/flush counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    fetch_if.master     bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t  state;
    logic [31:0]   fetch_pc, next_pc, addr_q;
    logic          req_q;
    fetch_entry_t  head, push_data;
    logic          full, empty, push, pop, wait_credit;
    logic [CW-1:0] count;
    logic [CW:0]   occ_after;

    assign next_pc   = fetch_pc + 32'(INS_BYTES);
    assign push      = (state == ST_WAIT) && bus.imem_ack && !bus.redirect;
    assign pop       = !empty && bus.ins_ready && !bus.redirect;
    assign push_data = '{pc: fetch_pc, ins: bus.imem_data};

    // Occupancy after this cycle's push/pop decides whether the next request may go out at once.
    assign occ_after   = {1'b0, count} + (CW+1)'(1) - (CW+1)'(pop);
    assign wait_credit = occ_after < (CW+1)'(DEPTH);

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (bus.redirect),
        .push     (push),
        .push_data(push_data),
        .pop      (pop),
        .head     (head),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            fetch_pc <= RESET_PC;
            req_q    <= 1'b0;
            addr_q   <= RESET_PC;
        end else if (bus.redirect) begin
            fetch_pc <= align_pc(bus.redirect_pc);
            // An ack landing with the redirect completes the old request, so nothing is left to drop.
            if (state != ST_IDLE) begin
                if (bus.imem_ack) begin
                    state <= ST_IDLE;
                    req_q <= 1'b0;
                end else begin
                    state <= ST_DROP;
                end
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!full) begin
                        req_q  <= 1'b1;
                        addr_q <= fetch_pc;
                        state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.imem_ack) begin
                        fetch_pc <= next_pc;
                        if (wait_credit) begin
                            addr_q <= next_pc;
                        end else begin
                            req_q <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_DROP: begin
                    if (bus.imem_ack) begin
                        req_q <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    req_q <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.imem_req  = req_q;
    assign bus.imem_addr = addr_q;
    assign bus.ins_valid = !empty;
    assign bus.ins       = head.ins;
    assign bus.ins_pc    = head.pc;

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (bus.ins_ready && empty && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
            if (bus.redirect && flush_cnt != '1) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic against a queue-level model.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fetch_if f();
    fetch_if f2();

`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt, flush_cnt, stall_hi, flush_hi;
`endif

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .bus(f)
`ifdef FETCH_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    // Second instance exercises the PC wrap; its memory acks every request in the same cycle.
    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) dut_hi (
        .clk(clk), .rst(rst), .bus(f2)
`ifdef FETCH_PERF_EN
        , .stall_cnt(stall_hi), .flush_cnt(flush_hi)
`endif
    );
    assign f2.imem_ack    = f2.imem_req;
    assign f2.imem_data   = f2.imem_addr;
    assign f2.ins_ready   = 1'b1;
    assign f2.redirect    = 1'b0;
    assign f2.redirect_pc = 32'h0;

    int          n_cmp = 0, n_bad = 0;
    logic        ready_i = 1'b0, redir_i = 1'b0;
    logic [31:0] redir_pc_i = 32'h0;
    int          lat = 0, wcnt = 0, cyc = 0;
    logic [31:0] q[$];
    logic [31:0] exp_fetch = 32'h0;
    bit          stale = 1'b0;
    logic [31:0] exp_stall = 0, exp_flush = 0;
    logic [31:0] acc_pc[$];
    int          acc_cyc[$];
    int          ack_cyc[$];
    logic [31:0] hi_addr[$];
    logic        prev_req = 1'b0, prev_ack = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: drive inputs, check outputs against the model, advance the model, step.
    task automatic cycle();
        logic ack, pop;
        f.ins_ready   = ready_i;
        f.redirect    = redir_i;
        f.redirect_pc = redir_pc_i;
        ack           = f.imem_req && (wcnt >= lat);
        f.imem_ack    = ack;
        f.imem_data   = ack ? memw(f.imem_addr) : $urandom;

        chk("ins_valid", 32'(f.ins_valid), 32'(q.size() != 0));
        if (f.ins_valid && q.size() != 0) begin
            chk("ins_pc", f.ins_pc, q[0]);
            chk("ins", f.ins, memw(q[0]));
        end
        if (f.imem_req && prev_req && !prev_ack) chk("addr_hold", f.imem_addr, prev_addr);
`ifdef FETCH_PERF_EN
        chk("stall_cnt", stall_cnt, exp_stall);
        chk("flush_cnt", flush_cnt, exp_flush);
`endif
        if (f2.imem_req) hi_addr.push_back(f2.imem_addr);

        if (ready_i && q.size() == 0) exp_stall++;
        pop = (q.size() != 0) && ready_i && !redir_i;
        if (redir_i) q.delete();
        else if (pop) begin
            acc_pc.push_back(q.pop_front());
            acc_cyc.push_back(cyc);
        end
        if (f.imem_req && ack) begin
            if (!stale && !redir_i) begin
                chk("fetch_addr", f.imem_addr, exp_fetch);
                q.push_back(exp_fetch);
                ack_cyc.push_back(cyc);
                exp_fetch += 32'd4;
            end
            stale = 1'b0;
        end
        if (redir_i) begin
            exp_fetch = redir_pc_i & ~32'h3;
            exp_flush++;
            if (f.imem_req && !ack) stale = 1'b1;
        end
        prev_req  = f.imem_req;
        prev_ack  = ack;
        prev_addr = f.imem_addr;

        @(posedge clk);
        #1;
        wcnt    = (prev_req && !ack) ? wcnt + 1 : 0;
        redir_i = 1'b0;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ready_i = 1'b0;
        redir_i = 1'b0;
        f.ins_ready = 1'b0;
        f.redirect  = 1'b0;
        f.imem_ack  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        q.delete(); acc_pc.delete(); acc_cyc.delete(); ack_cyc.delete(); hi_addr.delete();
        exp_fetch = 32'h0; stale = 1'b0; wcnt = 0; cyc = 0;
        exp_stall = 0; exp_flush = 0;
        prev_req = 1'b0; prev_ack = 1'b0; prev_addr = 32'h0;
        rst = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int mark;
        f.ins_ready = 1'b0; f.redirect = 1'b0; f.redirect_pc = 32'h0;
        f.imem_ack = 1'b0; f.imem_data = 32'h0;
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        // Reset state
        chk("rst_req", 32'(f.imem_req), 32'd0);
        chk("rst_addr", f.imem_addr, 32'h0);
        chk("rst_valid", 32'(f.ins_valid), 32'd0);
        chk("rst_ins", f.ins, 32'h0);
        chk("rst_ins_pc", f.ins_pc, 32'h0);
        chk("rst_addr_hi", f2.imem_addr, 32'hFFFF_FFF8);
`ifdef FETCH_PERF_EN
        chk("rst_stall", stall_cnt, 32'h0);
        chk("rst_flush", flush_cnt, 32'h0);
        chk("rst_stall_hi", stall_hi | flush_hi, 32'h0);
`endif

        // Same-cycle acks, always ready: one instruction per cycle
        do_reset();
        lat = 0; ready_i = 1'b1;
        run(10);
        chk("t1_count", 32'(acc_pc.size() >= 3 && ack_cyc.size() >= 1), 32'd1);
        if (acc_pc.size() >= 3 && ack_cyc.size() >= 1) begin
            chk("t1_pc0", acc_pc[0], 32'h0);
            chk("t1_pc1", acc_pc[1], 32'h4);
            chk("t1_pc2", acc_pc[2], 32'h8);
            chk("t1_lat", 32'(acc_cyc[0] - ack_cyc[0]), 32'd1);
            chk("t1_rate", 32'(acc_cyc[2] - acc_cyc[0]), 32'd2);
        end
        // PC wrap on the high-reset instance
        chk("t5_count", 32'(hi_addr.size() >= 3), 32'd1);
        if (hi_addr.size() >= 3) begin
            chk("t5_a0", hi_addr[0], 32'hFFFF_FFF8);
            chk("t5_a1", hi_addr[1], 32'hFFFF_FFFC);
            chk("t5_a2", hi_addr[2], 32'h0000_0000);
        end

        // Core stalled: queue fills to DEPTH and fetch stops
        do_reset();
        lat = 0; ready_i = 1'b0;
        run(10);
        chk("t2_acks", 32'(ack_cyc.size()), 32'd2);
        chk("t2_req_low", 32'(f.imem_req), 32'd0);
        ready_i = 1'b1;
        run(8);
        chk("t2_count", 32'(acc_pc.size() >= 3), 32'd1);
        if (acc_pc.size() >= 3) begin
            chk("t2_pc0", acc_pc[0], 32'h0);
            chk("t2_pc1", acc_pc[1], 32'h4);
            chk("t2_pc2", acc_pc[2], 32'h8);
        end

        // Redirect while a slow request is outstanding
        do_reset();
        lat = 3; ready_i = 1'b1;
        for (int k = 0; k < 60 && !(f.imem_req && f.imem_addr == 32'h8); k++) cycle();
        chk("t3_reach8", 32'(f.imem_req && f.imem_addr == 32'h8), 32'd1);
        cycle();
        redir_i = 1'b1; redir_pc_i = 32'h100;
        cycle();
        mark = acc_pc.size();
        for (int k = 0; k < 40 && !(f.imem_req && !stale); k++) cycle();
        chk("t3_newreq", 32'(f.imem_req && !stale), 32'd1);
        chk("t3_addr", f.imem_addr, 32'h100);
        for (int k = 0; k < 40 && acc_pc.size() <= mark; k++) cycle();
        chk("t3_acc", 32'(acc_pc.size() > mark), 32'd1);
        if (acc_pc.size() > mark) chk("t3_first_pc", acc_pc[mark], 32'h100);

        // Redirect coinciding with pop and ack, unaligned target
        do_reset();
        lat = 0; ready_i = 1'b1;
        for (int k = 0; k < 20 && !(f.ins_valid && f.imem_req); k++) cycle();
        chk("t4_busy", 32'(f.ins_valid && f.imem_req), 32'd1);
        redir_i = 1'b1; redir_pc_i = 32'h203;
        cycle();
        chk("t4_empty", 32'(f.ins_valid), 32'd0);
        mark = acc_pc.size();
        for (int k = 0; k < 10 && !f.imem_req; k++) cycle();
        chk("t4_addr", f.imem_addr, 32'h200);
        for (int k = 0; k < 10 && acc_pc.size() <= mark; k++) cycle();
        if (acc_pc.size() > mark) chk("t4_first_pc", acc_pc[mark], 32'h200);
        else chk("t4_acc", 32'd0, 32'd1);

        // Slow memory with two redirects, then async reset mid-request
        do_reset();
        lat = 4; ready_i = 1'b1;
        run(12);
        redir_i = 1'b1; redir_pc_i = 32'h40;
        cycle();
        run(9);
        redir_i = 1'b1; redir_pc_i = 32'h80;
        cycle();
        run(20);
        chk("t6_fetches", 32'(ack_cyc.size() >= 3), 32'd1);
`ifdef FETCH_PERF_EN
        chk("t6_flush", flush_cnt, 32'd2);
        chk("t6_stall", stall_cnt, exp_stall);
`endif
        for (int k = 0; k < 20 && !(f.imem_req && !stale); k++) cycle();
        chk("t6_inwait", 32'(f.imem_req), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_req", 32'(f.imem_req), 32'd0);
        chk("arst_addr", f.imem_addr, 32'h0);
        chk("arst_valid", 32'(f.ins_valid), 32'd0);
        chk("arst_ins", f.ins, 32'h0);
        chk("arst_ins_pc", f.ins_pc, 32'h0);
`ifdef FETCH_PERF_EN
        chk("arst_stall", stall_cnt, 32'h0);
        chk("arst_flush", flush_cnt, 32'h0);
`endif

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            lat     = $urandom_range(0, 3);
            ready_i = ($urandom % 4) != 0;
            if ($urandom % 16 == 0) begin
                redir_i    = 1'b1;
                redir_pc_i = $urandom & 32'h0000_0FFF;
            end
            cycle();
        end
        chk("rand_progress", 32'(acc_pc.size() > 100), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
